goertzel_synth: RTL and testbench

- Inverse companion to the sliding Goertzel DFT: takes per-bin complex amplitudes (re, im) with bin indices k and synthesises time-domain samples.
- Output per sample: x[n] = sum over bins of (re*cos(2*pi*k'*n/N_MAX) - im*sin(2*pi*k'*n/N_MAX)), where k' = k << (LOG_N_MAX - i_N).
- Sits on the closed-loop output path, driving the stimulus/DAC side from bin results produced by the analysis block.
- Sequential, single shared multiplier, double-buffered coefficient bank.

---
 rtl/goertzel_synth.sv | 195 +++++++++++++++++++
 tb/tb_goertzel_synth.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_synth.sv
// Inverse sliding-Goertzel synthesiser: one shared multiplier, double-buffered bin bank, o_valid 3*BIN_NUM+2 clocks after i_rd.
// i_rd is dropped while busy; define GOERTZEL_SYNTH_SAT_EN to saturate o_x instead of wrapping it.
module goertzel_synth #(
   parameter int    WIDTH     = 12,
   parameter int    N_MAX     = 512,
   parameter int    LOG_N_MAX = $clog2(N_MAX),
   parameter int    FRAC_BITS = 4,
   parameter int    BIN_NUM   = 4,
   parameter string INIT_FILE = "DFT_synth_coefficient_hex.txt"
) (
   input  logic                               i_sys_clk,
   input  logic                               i_sys_rst_n,
   input  logic [$clog2(LOG_N_MAX+1)-1:0]     i_N,
   input  logic                               i_wr,
   input  logic signed [WIDTH-1:0]            i_re,
   input  logic signed [WIDTH-1:0]            i_im,
   input  logic [LOG_N_MAX-1:0]               i_k,
   input  logic                               i_rd,
   output logic signed [WIDTH-1:0]            o_x,
   output logic                               o_valid,
   output logic                               o_busy,
   output logic                               o_pending
);
   localparam int NW   = $clog2(LOG_N_MAX+1);
   localparam int BW   = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
   localparam int PW   = 2*WIDTH;
   localparam int AW   = 2*WIDTH + $clog2(BIN_NUM) + 1;
   localparam logic [BW-1:0] LAST = BW'(BIN_NUM-1);

   typedef enum logic [2:0] {IDLE, FETCH, MAC_C, MAC_S, OUT} state_t;

   // Table image: word 2m = cos, word 2m+1 = sin of 2*pi*m/N_MAX, scaled by 2^FRAC_BITS.
   function automatic logic signed [WIDTH-1:0] trig_word(input int m, input bit want_sin);
      real ang, v;
      ang = 2.0 * 3.14159265358979323846 * m / N_MAX;
      v   = (want_sin ? $sin(ang) : $cos(ang)) * (2.0 ** FRAC_BITS);
      return WIDTH'($rtoi((v >= 0.0) ? v + 0.5 : v - 0.5));
   endfunction

   logic signed [WIDTH-1:0] rom_cos [N_MAX];
   logic signed [WIDTH-1:0] rom_sin [N_MAX];

   for (genvar m = 0; m < N_MAX; m++) begin : g_rom
      assign rom_cos[m] = trig_word(m, 1'b0);
      assign rom_sin[m] = trig_word(m, 1'b1);
   end

   logic signed [WIDTH-1:0]  sh_re  [BIN_NUM];
   logic signed [WIDTH-1:0]  sh_im  [BIN_NUM];
   logic [LOG_N_MAX-1:0]     sh_k   [BIN_NUM];
   logic signed [WIDTH-1:0]  act_re [BIN_NUM];
   logic signed [WIDTH-1:0]  act_im [BIN_NUM];
   logic [LOG_N_MAX-1:0]     act_k  [BIN_NUM];
   logic [LOG_N_MAX-1:0]     ph     [BIN_NUM];
   logic [BW-1:0]            wptr;
   logic [BW-1:0]            bin;

   state_t                   state, state_nx;
   logic                     swap;
   logic signed [WIDTH-1:0]  cos_r, sin_r;
   logic signed [AW-1:0]     acc;
   logic signed [WIDTH-1:0]  res;
   logic                     res_vld;

   logic [NW-1:0]            n_eff;
   logic [LOG_N_MAX-1:0]     kp;
   logic signed [WIDTH-1:0]  mul_a, mul_b;
   logic signed [PW-1:0]     prod;
   logic signed [AW-1:0]     prod_x;
   logic signed [AW-1:0]     acc_sh;
   logic signed [WIDTH-1:0]  res_nx;

   assign n_eff  = (i_N > NW'(LOG_N_MAX)) ? NW'(LOG_N_MAX) : i_N;
   assign kp     = act_k[bin] << (NW'(LOG_N_MAX) - n_eff);
   assign mul_a  = (state == MAC_S) ? act_im[bin] : act_re[bin];
   assign mul_b  = (state == MAC_S) ? sin_r : cos_r;
   assign prod   = PW'(mul_a) * PW'(mul_b);
   assign prod_x = AW'(prod);
   assign acc_sh = acc >>> FRAC_BITS;

`ifdef GOERTZEL_SYNTH_SAT_EN
   localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (WIDTH-1)) - 1);
   localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;
   assign res_nx = (acc_sh > SAT_HI) ? WIDTH'(SAT_HI) :
                   (acc_sh < SAT_LO) ? WIDTH'(SAT_LO) : WIDTH'(acc_sh);
`else
   assign res_nx = WIDTH'(acc_sh);
`endif

   // Shadow load path runs regardless of the sequencer; a set completing on a swap cycle stays pending.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         for (int b = 0; b < BIN_NUM; b++) begin
            sh_re[b] <= '0;
            sh_im[b] <= '0;
            sh_k[b]  <= '0;
         end
         wptr      <= '0;
         o_pending <= 1'b0;
      end else begin
         if (i_wr) begin
            sh_re[wptr] <= i_re;
            sh_im[wptr] <= i_im;
            sh_k[wptr]  <= i_k;
            wptr        <= (wptr == LAST) ? '0 : wptr + BW'(1);
         end
         if (i_wr && (wptr == LAST))
            o_pending <= 1'b1;
         else if (swap)
            o_pending <= 1'b0;
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         for (int b = 0; b < BIN_NUM; b++) begin
            act_re[b] <= '0;
            act_im[b] <= '0;
            act_k[b]  <= '0;
            ph[b]     <= '0;
         end
      end else if (swap) begin
         for (int b = 0; b < BIN_NUM; b++) begin
            act_re[b] <= sh_re[b];
            act_im[b] <= sh_im[b];
            act_k[b]  <= sh_k[b];
            ph[b]     <= '0;
         end
      end else if (state == MAC_S) begin
         ph[bin] <= ph[bin] + kp;
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) state <= IDLE;
      else              state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      swap     = 1'b0;
      case (state)
         IDLE:  if (i_rd) begin
                   swap     = o_pending;
                   state_nx = FETCH;
                end
         FETCH: state_nx = MAC_C;
         MAC_C: state_nx = MAC_S;
         MAC_S: state_nx = (bin == LAST) ? OUT : FETCH;
         OUT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // res is an output retiming stage so the wide shift/saturate does not feed o_x directly.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         acc     <= '0;
         bin     <= '0;
         cos_r   <= '0;
         sin_r   <= '0;
         res     <= '0;
         res_vld <= 1'b0;
         o_x     <= '0;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         res_vld <= 1'b0;
         o_valid <= res_vld;
         if (res_vld) o_x <= res;
         case (state)
            IDLE:  if (i_rd) begin
                      acc    <= '0;
                      bin    <= '0;
                      o_busy <= 1'b1;
                   end
            FETCH: begin
                      cos_r <= rom_cos[ph[bin]];
                      sin_r <= rom_sin[ph[bin]];
                   end
            MAC_C: acc <= acc + prod_x;
            MAC_S: begin
                      acc <= acc - prod_x;
                      if (bin != LAST) bin <= bin + BW'(1);
                   end
            OUT:   begin
                      res     <= res_nx;
                      res_vld <= 1'b1;
                      o_busy  <= 1'b0;
                   end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_goertzel_synth.sv
// Directed bench for goertzel_synth: expected samples queued at each read request, popped on o_valid.
module tb_goertzel_synth;
   logic                clk;
   logic                rst_n;
   logic [3:0]          n;
   logic                wr;
   logic signed [11:0]  re;
   logic signed [11:0]  im;
   logic [8:0]          k;
   logic                rd;
   logic signed [11:0]  x;
   logic                valid;
   logic                busy;
   logic                pending;

   goertzel_synth dut (
      .i_sys_clk  (clk),
      .i_sys_rst_n(rst_n),
      .i_N        (n),
      .i_wr       (wr),
      .i_re       (re),
      .i_im       (im),
      .i_k        (k),
      .i_rd       (rd),
      .o_x        (x),
      .o_valid    (valid),
      .o_busy     (busy),
      .o_pending  (pending)
   );

`ifdef GOERTZEL_SYNTH_SAT_EN
   localparam int OVF_EXP = 2047;
`else
   localparam int OVF_EXP = -4;
`endif

   logic signed [11:0] exp_q [$];
   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;
   int lat       = 0;
   int nv        = 0;
   int cos_seq [5] = '{100, 0, -100, 0, 100};
   int sin_seq [4] = '{0, -100, 0, 100};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      lat++;
   endtask

   task automatic write_bin(input int re_v, input int im_v, input int k_v);
      re = 12'(re_v);
      im = 12'(im_v);
      k  = 9'(k_v);
      wr = 1'b1;
      step();
      wr = 1'b0;
   endtask

   task automatic start_read(input int expv);
      exp_q.push_back(12'(expv));
      rd = 1'b1;
      @(posedge clk);
      #1;
      rd  = 1'b0;
      lat = 0;
   endtask

   task automatic finish_read(input string tag, input int extra_at);
      logic signed [11:0] e;
      while (valid !== 1'b1 && lat < 40) begin
         if (extra_at > 0 && lat == extra_at) rd = 1'b1;
         step();
         rd = 1'b0;
      end
      e = exp_q.pop_front();
      if (valid !== 1'b1) begin
         check($sformatf("%s timeout", tag), lat, 14);
      end else begin
         check($sformatf("%s latency", tag), lat, 14);
         check($sformatf("%s o_x", tag), x, e);
         check($sformatf("%s busy", tag), busy, 0);
         step();
         check($sformatf("%s pulse", tag), valid, 0);
      end
   endtask

   task automatic do_read(input int expv, input string tag);
      start_read(expv);
      finish_read(tag, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      n  = 4'd9;
      wr = 1'b0;
      re = '0;
      im = '0;
      k  = '0;
      rd = 1'b0;
      #12;
      check("reset o_x", x, 0);
      check("reset o_valid", valid, 0);
      check("reset o_busy", busy, 0);
      check("reset o_pending", pending, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // DC bin
      write_bin(100, 0, 0);
      for (int i = 0; i < 3; i++) write_bin(0, 0, 0);
      check("dc pending set", pending, 1);
      for (int i = 0; i < 5; i++) begin
         do_read(100, $sformatf("dc%0d", i));
         if (i == 0) check("dc pending clear", pending, 0);
      end

      // quarter-rate cosine then sine
      write_bin(100, 0, 128);
      for (int i = 0; i < 3; i++) write_bin(0, 0, 0);
      for (int i = 0; i < 5; i++) do_read(cos_seq[i], $sformatf("cos%0d", i));
      write_bin(0, 100, 128);
      for (int i = 0; i < 3; i++) write_bin(0, 0, 0);
      for (int i = 0; i < 4; i++) do_read(sin_seq[i], $sformatf("sin%0d", i));

      // accumulator overflow at the output width
      for (int i = 0; i < 4; i++) write_bin(2047, 0, 0);
      do_read(OVF_EXP, "ovf");

      // double buffer: a set written mid-sample stays in the shadow bank
      write_bin(100, 0, 128);
      for (int i = 0; i < 3; i++) write_bin(0, 0, 0);
      do_read(100, "db_a");
      start_read(0);
      write_bin(50, 0, 0);
      for (int i = 0; i < 3; i++) write_bin(0, 0, 0);
      check("db pending during busy", pending, 1);
      finish_read("db_busy", 0);
      check("db pending held", pending, 1);
      do_read(50, "db_swap");
      check("db pending cleared", pending, 0);

      // second i_rd while busy is dropped
      start_read(50);
      finish_read("ign", 3);
      nv = 0;
      repeat (20) begin
         step();
         if (valid === 1'b1) nv++;
      end
      check("ign extra valid", nv, 0);

      // async reset mid-sample with a full shadow set waiting
      rd = 1'b1;
      @(posedge clk);
      #1;
      rd  = 1'b0;
      lat = 0;
      for (int i = 0; i < 4; i++) write_bin(100, 0, 0);
      while (lat < 7) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst o_x", x, 0);
      check("rst o_valid", valid, 0);
      check("rst o_busy", busy, 0);
      check("rst o_pending", pending, 0);
      nv = 0;
      repeat (3) begin
         step();
         if (valid === 1'b1) nv++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         step();
         if (valid === 1'b1) nv++;
      end
      check("rst no valid", nv, 0);
      do_read(0, "post_rst");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
